down_counter: RTL and testbench
===============================

Name: down_counter

Overview:
- Decrementing countdown counter; the decrement-side counterpart to the team's free-running up-counter.
- Software or control logic loads a start value. Each qualified i__dec tick decrements it.
- A one-cycle expiry pulse is emitted when the count reaches zero.
- Used for timeouts, credit drain and packet-gap timing in the pipeline stages.

Parameters:
- COUNT_WIDTH, 32, width of count, load value and outputs.
- INIT_VALUE, 0, count value after reset.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous active-low reset (asserted when 0).
- i__load  input  1  load strobe; samples i__load_value.
- i__load_value  input  COUNT_WIDTH  start value for countdown.
- i__dec  input  1  decrement request (one tick).
- i__halt  input  1  freeze; blocks decrement while high.
- o__count  output  COUNT_WIDTH  registered current count.
- o__count__next  output  COUNT_WIDTH  combinational next-state count.
- o__busy  output  1  state is RUN or HOLD.
- o__expire  output  1  registered one-cycle pulse; count just reached 0 via decrement.
- o__underflow  output  1  registered one-cycle pulse; i__dec accepted while count==0.

Behaviour:
- Reset (reset==0, asynchronous):
  - count=INIT_VALUE; state=IDLE if INIT_VALUE==0, else RUN.
  - o__expire=0; o__underflow=0.
  - Registered reload value = INIT_VALUE.
  - Release is synchronous to the next clk edge.
- States: IDLE (count==0), RUN (count>0, counting), HOLD (count>0, halted).
- Priority per cycle: load > halt > dec.
- i__load=1:
  - count_next=i__load_value; reload register updated.
  - Next state: IDLE if value==0; else HOLD if i__halt; else RUN.
  - No expire or underflow pulse in a load cycle, even if i__dec=1.
- RUN, i__halt=1: count holds; go to HOLD.
- HOLD, i__halt=0: return to RUN the next cycle. The decrement applies in that same cycle if i__dec=1.
- RUN, i__dec=1, !i__halt: count_next=count-1.
  - If count==1: next state IDLE; o__expire=1 in the following cycle, aligned with o__count==0.
- IDLE, i__dec=1: count saturates at 0 (no wrap to all-ones); o__underflow=1 for one cycle.
- IDLE, i__halt=1: no effect; stays IDLE.
- o__count__next always equals the value o__count takes at the next edge (reset excepted).
- Arithmetic:
  - Subtraction is COUNT_WIDTH bits wide.
  - Zero detection is on the full width.
  - Loading all-ones is legal: takes 2^COUNT_WIDTH-1 decrements to expire.
- Reset mid-countdown aborts immediately; no expire pulse.
- o__busy = (state != IDLE), registered.

Optional Feature:
- Macro DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - On the expiring decrement (count==1), count_next = reload register instead of 0 and state stays RUN.
  - o__expire still pulses; o__count never shows 0 for that expiry.
  - A reload value of 0 makes expiry go to IDLE as normal.
- Undefined: reload register is not used for expiry; expiry always lands in IDLE with count 0.

Decomposition:
- Package counter_pkg:
  - state enum (IDLE, RUN, HOLD), 2-bit.
  - Default COUNT_WIDTH constant.
  - Shared by the up-counter and down_counter.
- No sub-module: single module with one always_comb for next-state/next-count and one always_ff with async reset.

Test Plan:
- Reset deasserted, load 3, i__dec held high → o__count 3,2,1,0; o__expire high exactly in the cycle o__count==0; o__busy falls with it.
- Load 5, dec 2 ticks, i__halt=1 with i__dec=1 for 4 cycles, then release → count stays 3 during halt; after release reaches 0 after 3 more ticks.
- From IDLE, pulse i__dec → o__count stays 0; o__underflow one-cycle pulse; no o__expire.
- Load 1 and i__dec=1 in same cycle, then load 0 → count becomes 1 (no decrement); then 0 with no expire; state IDLE.
- Load all-ones (COUNT_WIDTH=8: 255), 255 decs → expire on the 255th; the 256th dec gives an underflow pulse.
- With DOWN_COUNTER_AUTO_RELOAD_EN, load 2, continuous dec → sequence 2,1,2,1…; o__expire every second cycle; o__busy stays 1.
- Assert reset (reset=0) while count=7 → o__count=0 and o__expire=0 asynchronously.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and defaults for the up/down counters
package counter_pkg;

    localparam int COUNT_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable countdown counter with expiry/underflow pulses; optional DOWN_COUNTER_AUTO_RELOAD_EN
module down_counter
    import counter_pkg::*;
#(
    parameter int                     COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
    parameter logic [COUNT_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i__load,
    input  logic [COUNT_WIDTH-1:0] i__load_value,
    input  logic                   i__dec,
    input  logic                   i__halt,
    output logic [COUNT_WIDTH-1:0] o__count,
    output logic [COUNT_WIDTH-1:0] o__count__next,
    output logic                   o__busy,
    output logic                   o__expire,
    output logic                   o__underflow
);

    localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam state_t RESET_STATE = (INIT_VALUE == '0) ? IDLE : RUN;

    state_t                  state;
    state_t                  state_next;
    logic [COUNT_WIDTH-1:0]  count;
    logic [COUNT_WIDTH-1:0]  count_next;
    logic                    expire_next;
    logic                    underflow_next;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [COUNT_WIDTH-1:0]  reload_q;
    logic [COUNT_WIDTH-1:0]  reload_next;
`endif

    // Next state/count: load beats halt, halt beats decrement.
    always_comb begin
        state_next     = state;
        count_next     = count;
        expire_next    = 1'b0;
        underflow_next = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload_next    = reload_q;
`endif
        if (i__load) begin
            count_next = i__load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_next = i__load_value;
`endif
            if (i__load_value == '0) begin
                state_next = IDLE;
            end else if (i__halt) begin
                state_next = HOLD;
            end else begin
                state_next = RUN;
            end
        end else begin
            case (state)
                IDLE: begin
                    // Saturate at zero; halt also masks the underflow report.
                    count_next = '0;
                    if (i__dec && !i__halt) begin
                        underflow_next = 1'b1;
                    end
                end
                RUN, HOLD: begin
                    if (i__halt) begin
                        state_next = HOLD;
                    end else begin
                        // Leaving HOLD still honours a decrement in the same cycle.
                        state_next = RUN;
                        if (i__dec) begin
                            if (count == ONE) begin
                                expire_next = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                                if (reload_q != '0) begin
                                    count_next = reload_q;
                                    state_next = RUN;
                                end else begin
                                    count_next = '0;
                                    state_next = IDLE;
                                end
`else
                                count_next = '0;
                                state_next = IDLE;
`endif
                            end else begin
                                count_next = count - ONE;
                            end
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // State, count and pulse registers; reset aborts any countdown without a pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RESET_STATE;
            count        <= INIT_VALUE;
            o__expire    <= 1'b0;
            o__underflow <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q     <= INIT_VALUE;
`endif
        end else begin
            state        <= state_next;
            count        <= count_next;
            o__expire    <= expire_next;
            o__underflow <= underflow_next;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q     <= reload_next;
`endif
        end
    end

    assign o__count       = count;
    assign o__count__next = count_next;
    assign o__busy        = (state != IDLE);

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - directed self-checking bench for down_counter (8-bit)
module tb_down_counter;

    logic       clk;
    logic       reset;
    logic       i__load;
    logic [7:0] i__load_value;
    logic       i__dec;
    logic       i__halt;
    logic [7:0] o__count;
    logic [7:0] o__count__next;
    logic       o__busy;
    logic       o__expire;
    logic       o__underflow;

    int total;
    int bad;

    down_counter #(
        .COUNT_WIDTH (8),
        .INIT_VALUE  (8'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i__load        (i__load),
        .i__load_value  (i__load_value),
        .i__dec         (i__dec),
        .i__halt        (i__halt),
        .o__count       (o__count),
        .o__count__next (o__count__next),
        .o__busy        (o__busy),
        .o__expire      (o__expire),
        .o__underflow   (o__underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i__load = 1'b0;
        i__load_value = 8'd0;
        i__dec = 1'b0;
        i__halt = 1'b0;
        #12;
        total++; if (o__count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", o__count); end
        total++; if (o__busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", o__busy); end
        total++; if (o__expire !== 1'b0) begin bad++; $display("FAIL reset_expire: got %0b expected 0", o__expire); end
        total++; if (o__underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow: got %0b expected 0", o__underflow); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_underflow();
        i__dec = 1'b1;
        tick();
        i__dec = 1'b0;
        total++; if (o__count !== 8'd0) begin bad++; $display("FAIL uf_count: got %0d expected 0", o__count); end
        total++; if (o__underflow !== 1'b1) begin bad++; $display("FAIL uf_pulse: got %0b expected 1", o__underflow); end
        total++; if (o__expire !== 1'b0) begin bad++; $display("FAIL uf_no_expire: got %0b expected 0", o__expire); end
        tick();
        total++; if (o__underflow !== 1'b0) begin bad++; $display("FAIL uf_one_cycle: got %0b expected 0", o__underflow); end
    endtask

    task automatic test_load_priority();
        i__load = 1'b1;
        i__load_value = 8'd1;
        i__dec = 1'b1;
        tick();
        total++; if (o__count !== 8'd1) begin bad++; $display("FAIL ld1_count: got %0d expected 1", o__count); end
        total++; if (o__expire !== 1'b0) begin bad++; $display("FAIL ld1_expire: got %0b expected 0", o__expire); end
        total++; if (o__busy !== 1'b1) begin bad++; $display("FAIL ld1_busy: got %0b expected 1", o__busy); end
        i__load_value = 8'd0;
        i__dec = 1'b0;
        tick();
        i__load = 1'b0;
        total++; if (o__count !== 8'd0) begin bad++; $display("FAIL ld0_count: got %0d expected 0", o__count); end
        total++; if (o__expire !== 1'b0) begin bad++; $display("FAIL ld0_expire: got %0b expected 0", o__expire); end
        total++; if (o__busy !== 1'b0) begin bad++; $display("FAIL ld0_busy: got %0b expected 0", o__busy); end
    endtask

    task automatic test_basic();
        i__load = 1'b1;
        i__load_value = 8'd3;
        i__dec = 1'b1;
        #1;
        total++; if (o__count__next !== 8'd3) begin bad++; $display("FAIL basic_next: got %0d expected 3", o__count__next); end
        for (int i = 0; i < 4; i++) begin
            tick();
            i__load = 1'b0;
            total++; if (o__count !== 8'(3 - i)) begin bad++; $display("FAIL basic_count[%0d]: got %0d expected %0d", i, o__count, 3 - i); end
            total++; if (o__expire !== (i == 3)) begin bad++; $display("FAIL basic_expire[%0d]: got %0b expected %0b", i, o__expire, (i == 3)); end
            total++; if (o__busy !== (i != 3)) begin bad++; $display("FAIL basic_busy[%0d]: got %0b expected %0b", i, o__busy, (i != 3)); end
        end
        i__dec = 1'b0;
        tick();
        total++; if (o__expire !== 1'b0) begin bad++; $display("FAIL basic_expire_end: got %0b expected 0", o__expire); end
    endtask

    task automatic test_halt();
        i__load = 1'b1;
        i__load_value = 8'd5;
        tick();
        i__load = 1'b0;
        total++; if (o__count !== 8'd5) begin bad++; $display("FAIL halt_load: got %0d expected 5", o__count); end
        i__dec = 1'b1;
        tick();
        tick();
        total++; if (o__count !== 8'd3) begin bad++; $display("FAIL halt_pre: got %0d expected 3", o__count); end
        i__halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (o__count !== 8'd3) begin bad++; $display("FAIL halt_hold[%0d]: got %0d expected 3", i, o__count); end
            total++; if (o__busy !== 1'b1) begin bad++; $display("FAIL halt_busy[%0d]: got %0b expected 1", i, o__busy); end
        end
        total++; if (o__count__next !== 8'd3) begin bad++; $display("FAIL halt_next: got %0d expected 3", o__count__next); end
        i__halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (o__count !== 8'(2 - i)) begin bad++; $display("FAIL halt_run[%0d]: got %0d expected %0d", i, o__count, 2 - i); end
            total++; if (o__expire !== (i == 2)) begin bad++; $display("FAIL halt_expire[%0d]: got %0b expected %0b", i, o__expire, (i == 2)); end
        end
        i__dec = 1'b0;
        tick();
    endtask

    task automatic test_all_ones();
        int pulses;
        pulses = 0;
        i__load = 1'b1;
        i__load_value = 8'd255;
        tick();
        i__load = 1'b0;
        total++; if (o__count !== 8'd255) begin bad++; $display("FAIL ones_load: got %0d expected 255", o__count); end
        i__dec = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (o__expire === 1'b1) pulses++;
        end
        total++; if (o__count !== 8'd0) begin bad++; $display("FAIL ones_final: got %0d expected 0", o__count); end
        total++; if (o__expire !== 1'b1) begin bad++; $display("FAIL ones_expire_last: got %0b expected 1", o__expire); end
        total++; if (pulses != 1) begin bad++; $display("FAIL ones_pulse_count: got %0d expected 1", pulses); end
        tick();
        total++; if (o__underflow !== 1'b1) begin bad++; $display("FAIL ones_underflow: got %0b expected 1", o__underflow); end
        total++; if (o__count !== 8'd0) begin bad++; $display("FAIL ones_saturate: got %0d expected 0", o__count); end
        i__dec = 1'b0;
        tick();
    endtask

    task automatic test_auto_reload();
        i__load = 1'b1;
        i__load_value = 8'd2;
        i__dec = 1'b1;
        tick();
        i__load = 1'b0;
        total++; if (o__count !== 8'd2) begin bad++; $display("FAIL ar_load: got %0d expected 2", o__count); end
        for (int i = 1; i <= 6; i++) begin
            tick();
            total++; if (o__count !== ((i % 2 == 1) ? 8'd1 : 8'd2)) begin bad++; $display("FAIL ar_count[%0d]: got %0d", i, o__count); end
            total++; if (o__expire !== (i % 2 == 0)) begin bad++; $display("FAIL ar_expire[%0d]: got %0b expected %0b", i, o__expire, (i % 2 == 0)); end
            total++; if (o__busy !== 1'b1) begin bad++; $display("FAIL ar_busy[%0d]: got %0b expected 1", i, o__busy); end
        end
        i__dec = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        i__load = 1'b1;
        i__load_value = 8'd7;
        tick();
        i__load = 1'b0;
        total++; if (o__count !== 8'd7) begin bad++; $display("FAIL mid_load: got %0d expected 7", o__count); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (o__count !== 8'd0) begin bad++; $display("FAIL mid_count: got %0d expected 0", o__count); end
        total++; if (o__expire !== 1'b0) begin bad++; $display("FAIL mid_expire: got %0b expected 0", o__expire); end
        total++; if (o__busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b expected 0", o__busy); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        total++; if (o__count !== 8'd0) begin bad++; $display("FAIL mid_after: got %0d expected 0", o__count); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_underflow();
        test_load_priority();
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_basic();
        test_halt();
        test_all_ones();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
